pe_feeder: RTL and testbench

- Drives one registered PE tile (PE_64 behind its I/O-register wrapper) from the array-controller side.
- Accepts a command (optional D preload, then N A/B beats) plus a ready/valid A/B operand stream.
- Emits the PE input bundle: a, b, d, valid, control_propagate, control_shift.
- Toggles the double-buffer propagate bit on each preload and inserts drain bubbles so results leave the PE pipeline before the next command.

---
 rtl/pe_feeder_pkg.sv | 21 ++
 rtl/pe_feeder_out_reg.sv | 55 +++++
 rtl/pe_feeder.sv | 135 +++++++++++++
 tb/tb_pe_feeder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_feeder_pkg.sv
// pe_feeder_pkg: constants and types shared by the PE feeder files.
//   DBITS_DEF        : d/c accumulator width (mirrors dbits in parameters.v)
//   A_W/B_W/SHIFT_W  : PE operand widths for a, b and rounding shift
//   FLUSH_CYCLES_DEF : bubble cycles needed to drain the wrapped PE
//   state_t          : feeder FSM states
package pe_feeder_pkg;

  localparam int DBITS_DEF        = 32;
  localparam int A_W              = 8;
  localparam int B_W              = 19;
  localparam int SHIFT_W          = 6;
  localparam int FLUSH_CYCLES_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRELOAD = 2'd1,
    S_COMPUTE = 2'd2,
    S_FLUSH   = 2'd3
  } state_t;

endpackage

// File: rtl/pe_feeder_out_reg.sv
// pe_feeder_out_reg: registered PE input bundle.
//   CLK, RST   : clock, synchronous active-low reset
//   pre_load   : load a D preload beat (a=b=0, d=pre_d, flip propagate)
//   beat_load  : load an A/B beat (d=0)
//   shift_load : capture a new rounding shift
//   a/b/d/valid/propagate/shift : registered outputs toward the PE
// Without a load, valid drops to 0 and a/b/d hold their last values.
module pe_feeder_out_reg
  import pe_feeder_pkg::*;
#(
  parameter int DBITS = DBITS_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               pre_load,
  input  logic               beat_load,
  input  logic               shift_load,
  input  logic [DBITS-1:0]   pre_d,
  input  logic [A_W-1:0]     beat_a,
  input  logic [B_W-1:0]     beat_b,
  input  logic [SHIFT_W-1:0] shift_in,
  output logic [A_W-1:0]     a,
  output logic [B_W-1:0]     b,
  output logic [DBITS-1:0]   d,
  output logic               valid,
  output logic               propagate,
  output logic [SHIFT_W-1:0] shift
);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      a         <= '0;
      b         <= '0;
      d         <= '0;
      valid     <= 1'b0;
      propagate <= 1'b0;
      shift     <= '0;
    end else begin
      valid <= pre_load | beat_load;
      if (pre_load) begin
        a         <= '0;
        b         <= '0;
        d         <= pre_d;
        // Each preload swaps the PE's double buffer.
        propagate <= ~propagate;
      end else if (beat_load) begin
        a <= beat_a;
        b <= beat_b;
        d <= '0;
      end
      if (shift_load) shift <= shift_in;
    end
  end

endmodule

// File: rtl/pe_feeder.sv
// pe_feeder: feeds one registered PE tile from the array-controller side.
//   CLK, RST          : clock, synchronous active-low reset
//   cmd_*             : command channel (preload flag, d, beat count, shift)
//   in_valid/in_ready : A/B operand stream (in_a, in_b)
//   io_in_*1          : registered PE input bundle
//   done              : one-cycle pulse on return to IDLE
//   stall_cnt         : (PE_FEEDER_STALL_CNT_EN only) COMPUTE cycles with
//                       in_valid low, saturating, cleared on command accept
//
// Handshakes: a transfer happens on a rising CLK edge where valid and ready
// are both high. cmd_ready is high only in IDLE and in_ready only in COMPUTE
// while beats remain; neither ready depends on its valid, and an initiator
// must hold valid and payload stable until the transfer.
//
// After the last beat FLUSH_CYCLES bubbles are inserted so results leave the
// wrapper registers and PE pipeline before the next command starts.
module pe_feeder
  import pe_feeder_pkg::*;
#(
  parameter int DBITS        = DBITS_DEF,
  parameter int LEN_W        = 8,
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_preload,
  input  logic [DBITS-1:0]   cmd_d,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [SHIFT_W-1:0] cmd_shift,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_W-1:0]     in_a,
  input  logic [B_W-1:0]     in_b,
  output logic [A_W-1:0]     io_in_a1,
  output logic [B_W-1:0]     io_in_b1,
  output logic [DBITS-1:0]   io_in_d1,
  output logic               io_in_valid1,
  output logic               io_in_control_propagate1,
  output logic [SHIFT_W-1:0] io_in_control_shift1,
  output logic               done
`ifdef PE_FEEDER_STALL_CNT_EN
  ,output logic [15:0]       stall_cnt
`endif
);

  localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

  state_t           state;
  logic [LEN_W-1:0] cnt;
  logic [FC_W-1:0]  flush_cnt;
  logic [DBITS-1:0] d_q;
  logic             accept;
  logic             beat;

  assign cmd_ready = (state == S_IDLE);
  // A len==0 COMPUTE visit takes no beats, so in_ready stays low then.
  assign in_ready  = (state == S_COMPUTE) && (cnt != '0);
  assign accept    = cmd_ready && cmd_valid;
  assign beat      = in_ready && in_valid;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= S_IDLE;
      cnt       <= '0;
      flush_cnt <= '0;
      d_q       <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          flush_cnt <= '0;
          if (cmd_valid) begin
            cnt   <= cmd_len;
            d_q   <= cmd_d;
            state <= cmd_preload ? S_PRELOAD : S_COMPUTE;
          end
        end
        S_PRELOAD: begin
          state <= (cnt == '0) ? S_FLUSH : S_COMPUTE;
        end
        S_COMPUTE: begin
          if (cnt == '0) begin
            state <= S_FLUSH;
          end else if (beat) begin
            cnt <= cnt - LEN_W'(1);
            if (cnt == LEN_W'(1)) state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (flush_cnt == FC_W'(FLUSH_CYCLES - 1)) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt + FC_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  pe_feeder_out_reg #(
    .DBITS(DBITS)
  ) u_out_reg (
    .CLK        (CLK),
    .RST        (RST),
    .pre_load   (state == S_PRELOAD),
    .beat_load  (beat),
    .shift_load (accept),
    .pre_d      (d_q),
    .beat_a     (in_a),
    .beat_b     (in_b),
    .shift_in   (cmd_shift),
    .a          (io_in_a1),
    .b          (io_in_b1),
    .d          (io_in_d1),
    .valid      (io_in_valid1),
    .propagate  (io_in_control_propagate1),
    .shift      (io_in_control_shift1)
  );

`ifdef PE_FEEDER_STALL_CNT_EN
  always_ff @(posedge CLK) begin
    if (!RST || accept) begin
      stall_cnt <= '0;
    end else if (state == S_COMPUTE && !in_valid && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pe_feeder.sv
// tb_pe_feeder: randomized self-checking bench for pe_feeder.
// The reference model is a per-command schedule: accept, optional preload
// beat, the operand beats as offered, FLUSH_CYCLES bubbles, then done.
module tb_pe_feeder;
  import pe_feeder_pkg::*;

  localparam int DW = DBITS_DEF;
  localparam int LW = 8;
  localparam int FC = 4;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic               cmd_preload = 1'b0;
  logic [DW-1:0]      cmd_d = '0;
  logic [LW-1:0]      cmd_len = '0;
  logic [SHIFT_W-1:0] cmd_shift = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [A_W-1:0]     in_a = '0;
  logic [B_W-1:0]     in_b = '0;
  logic [A_W-1:0]     io_in_a1;
  logic [B_W-1:0]     io_in_b1;
  logic [DW-1:0]      io_in_d1;
  logic               io_in_valid1;
  logic               io_in_control_propagate1;
  logic [SHIFT_W-1:0] io_in_control_shift1;
  logic               done;
`ifdef PE_FEEDER_STALL_CNT_EN
  logic [15:0]        stall_cnt;
`endif

  pe_feeder #(.DBITS(DW), .LEN_W(LW), .FLUSH_CYCLES(FC)) dut (
    .CLK                      (CLK),
    .RST                      (RST),
    .cmd_valid                (cmd_valid),
    .cmd_ready                (cmd_ready),
    .cmd_preload              (cmd_preload),
    .cmd_d                    (cmd_d),
    .cmd_len                  (cmd_len),
    .cmd_shift                (cmd_shift),
    .in_valid                 (in_valid),
    .in_ready                 (in_ready),
    .in_a                     (in_a),
    .in_b                     (in_b),
    .io_in_a1                 (io_in_a1),
    .io_in_b1                 (io_in_b1),
    .io_in_d1                 (io_in_d1),
    .io_in_valid1             (io_in_valid1),
    .io_in_control_propagate1 (io_in_control_propagate1),
    .io_in_control_shift1     (io_in_control_shift1),
    .done                     (done)
`ifdef PE_FEEDER_STALL_CNT_EN
    ,.stall_cnt               (stall_cnt)
`endif
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [A_W+B_W-1:0] exp_q[$];

  // Expected PE-side state
  logic [A_W-1:0]     m_a = '0;
  logic [B_W-1:0]     m_b = '0;
  logic [DW-1:0]      m_d = '0;
  logic               m_prop = 1'b0;
  logic [SHIFT_W-1:0] m_shift = '0;
  int                 m_stall = 0;

  // Next command to offer early (during FLUSH)
  bit                 pend_en = 0;
  logic               pend_pre;
  logic [DW-1:0]      pend_d;
  logic [LW-1:0]      pend_len;
  logic [SHIFT_W-1:0] pend_shift;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_pe(input string pfx, input logic ev, input logic edone, input logic ecr);
    check({pfx, ".valid"}, 64'(io_in_valid1), 64'(ev));
    check({pfx, ".a"}, 64'(io_in_a1), 64'(m_a));
    check({pfx, ".b"}, 64'(io_in_b1), 64'(m_b));
    check({pfx, ".d"}, 64'(io_in_d1), 64'(m_d));
    check({pfx, ".prop"}, 64'(io_in_control_propagate1), 64'(m_prop));
    check({pfx, ".shift"}, 64'(io_in_control_shift1), 64'(m_shift));
    check({pfx, ".done"}, 64'(done), 64'(edone));
    check({pfx, ".cmd_ready"}, 64'(cmd_ready), 64'(ecr));
  endtask

  // ---------------- driver ----------------
  // Runs one command from a negedge in IDLE to the negedge where done shows.
  task automatic run_cmd(input logic pre, input logic [DW-1:0] d, input int len,
                         input logic [SHIFT_W-1:0] sh, input bit use_pat,
                         input logic [15:0] pat, input int pct);
    int left;
    int idx;
    logic v;
    logic [A_W+B_W-1:0] ab;
    cmd_valid   = 1'b1;
    cmd_preload = pre;
    cmd_d       = d;
    cmd_len     = LW'(len);
    cmd_shift   = sh;
    check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    check("in_ready_idle", 64'(in_ready), 64'd0);
    @(negedge CLK);
    // Scramble the command fields so latching is exercised.
    cmd_valid = 1'b0;
    cmd_d     = DW'($urandom);
    cmd_len   = LW'($urandom);
    cmd_shift = SHIFT_W'($urandom);
    m_shift   = sh;
    m_stall   = 0;
    check("accept.cmd_ready", 64'(cmd_ready), 64'd0);
    check("accept.done", 64'(done), 64'd0);
    check("accept.shift", 64'(io_in_control_shift1), 64'(m_shift));
    if (pre) begin
      @(negedge CLK);
      m_prop = ~m_prop;
      m_d    = d;
      m_a    = '0;
      m_b    = '0;
      check_pe("preload", 1'b1, 1'b0, 1'b0);
    end else if (len == 0) begin
      in_valid = 1'b0;
      @(negedge CLK);
      m_stall++;
      check_pe("empty", 1'b0, 1'b0, 1'b0);
    end
    left = len;
    idx  = 0;
    while (left > 0) begin
      v = use_pat ? pat[idx % 16] : logic'($urandom_range(0, 99) < pct);
      in_valid = v;
      in_a     = A_W'($urandom);
      in_b     = B_W'($urandom);
      check("beat.in_ready", 64'(in_ready), 64'd1);
      if (v) exp_q.push_back({in_b, in_a});
      @(negedge CLK);
      in_valid = 1'b0;
      if (v) begin
        ab   = exp_q.pop_front();
        m_a  = ab[A_W-1:0];
        m_b  = ab[A_W+B_W-1:A_W];
        m_d  = '0;
        left--;
      end else begin
        m_stall++;
      end
      check_pe("beat", v, 1'b0, 1'b0);
      idx++;
    end
    for (int j = 0; j < FC; j++) begin
      if (pend_en && j == 0) begin
        cmd_valid   = 1'b1;
        cmd_preload = pend_pre;
        cmd_d       = pend_d;
        cmd_len     = pend_len;
        cmd_shift   = pend_shift;
      end
      @(negedge CLK);
      check("flush.in_ready", 64'(in_ready), 64'd0);
      check_pe("flush", 1'b0, logic'(j == FC - 1), logic'(j == FC - 1));
    end
    pend_en = 0;
`ifdef PE_FEEDER_STALL_CNT_EN
    check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
  endtask

  task automatic run_reset_mid();
    cmd_valid   = 1'b1;
    cmd_preload = 1'b1;
    cmd_d       = DW'($urandom);
    cmd_len     = LW'(5);
    cmd_shift   = SHIFT_W'(7);
    @(negedge CLK);
    cmd_valid = 1'b0;
    m_shift   = 6'd7;
    @(negedge CLK);
    m_prop = ~m_prop;
    m_d    = cmd_d;
    m_a    = '0;
    m_b    = '0;
    check("rst.pre.prop", 64'(io_in_control_propagate1), 64'(m_prop));
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_a     = A_W'($urandom);
      in_b     = B_W'($urandom);
      @(negedge CLK);
      check("rst.beat.valid", 64'(io_in_valid1), 64'd1);
    end
    in_valid = 1'b1;
    RST      = 1'b0;
    @(negedge CLK);
    in_valid = 1'b0;
    m_a = '0; m_b = '0; m_d = '0; m_prop = 1'b0; m_shift = '0;
    exp_q.delete();
    check("rst.in_ready", 64'(in_ready), 64'd0);
    check_pe("rst", 1'b0, 1'b0, 1'b1);
`ifdef PE_FEEDER_STALL_CNT_EN
    check("rst.stall_cnt", 64'(stall_cnt), 64'd0);
`endif
    RST = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      check_pe("post_rst", 1'b0, 1'b0, 1'b1);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    check_pe("reset", 1'b0, 1'b0, 1'b1);
    check("reset.in_ready", 64'(in_ready), 64'd0);
    RST = 1'b1;
    @(negedge CLK);

    // Preload then three back-to-back beats.
    run_cmd(1'b1, DW'(32'h1234), 3, 6'd3, 1'b1, 16'hFFFF, 0);
    // Second preload flips propagate back.
    run_cmd(1'b1, DW'($urandom), 2, 6'd5, 1'b1, 16'hFFFF, 0);
    // No preload: propagate unchanged.
    run_cmd(1'b0, DW'($urandom), 2, 6'd1, 1'b0, 16'h0, 70);
    // Gapped operands 1,0,0,1,1.
    run_cmd(1'b0, DW'($urandom), 3, 6'd2, 1'b1, 16'b11001, 0);
    // Empty commands.
    run_cmd(1'b0, DW'($urandom), 0, 6'd4, 1'b0, 16'h0, 50);
    run_cmd(1'b1, DW'($urandom), 0, 6'd8, 1'b0, 16'h0, 50);
    // Next command held during FLUSH; shift 9 appears only after accept.
    pend_en    = 1;
    pend_pre   = 1'b1;
    pend_d     = DW'($urandom);
    pend_len   = LW'(2);
    pend_shift = 6'd9;
    run_cmd(1'b0, DW'($urandom), 1, 6'd11, 1'b0, 16'h0, 50);
    run_cmd(pend_pre, pend_d, 2, 6'd9, 1'b0, 16'h0, 80);
    // Reset mid-COMPUTE.
    run_reset_mid();
    // Maximum beat count.
    run_cmd(1'b1, DW'($urandom), 255, SHIFT_W'($urandom), 1'b0, 16'h0, 90);
    // Random commands.
    for (int i = 0; i < 12; i++) begin
      run_cmd(logic'($urandom_range(0, 1)), DW'($urandom), $urandom_range(0, 6),
              SHIFT_W'($urandom), 1'b0, 16'h0, 60);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
